// File: rtl/fir4_mac_if.sv
// Stream bundle for fir4_mac: sample input side
// and filtered-result output side.
interface fir4_mac_if;
  logic              in_data_valid_unused;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [17:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fir4_mac.sv
// 4-tap FIR, one multiply-accumulate per clock,
// result held until the consumer takes it.
module fir4_mac #(
  parameter logic signed [7:0] C0 = 8'sd1,
  parameter logic signed [7:0] C1 = 8'sd3,
  parameter logic signed [7:0] C2 = 8'sd3,
  parameter logic signed [7:0] C3 = 8'sd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  fir4_mac_if.slave  bus,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]         r_x0;
  logic [7:0]         r_x1;
  logic [7:0]         r_x2;
  logic [7:0]         r_x3;
  logic signed [17:0] r_acc;
  logic signed [17:0] r_out;
  logic [1:0]         r_k;

  logic signed [7:0]  w_coef;
  logic [7:0]         w_xk;
  logic signed [8:0]  w_xs;
  logic signed [16:0] w_prod;
  logic signed [17:0] w_sum;
  logic               w_accept;
  logic               w_last;

  always_comb begin
    w_coef = C0;
    w_xk   = r_x0;
    unique case (r_k)
      2'd0: begin w_coef = C0; w_xk = r_x0; end
      2'd1: begin w_coef = C1; w_xk = r_x1; end
      2'd2: begin w_coef = C2; w_xk = r_x2; end
      2'd3: begin w_coef = C3; w_xk = r_x3; end
      default: ;
    endcase
  end

  // Samples are unsigned: a zero sign bit keeps the product signed-correct.
  assign w_xs     = $signed({1'b0, w_xk});
  assign w_prod   = w_coef * w_xs;
  assign w_sum    = r_acc + {w_prod[16], w_prod};
  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_k == 2'd3);

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = IDLE;
    end else begin
      unique case (1'b1)
        r_state == IDLE:
          if (bus.in_valid) w_next = MAC;
        r_state == MAC:
          if (w_last) w_next = HOLD;
        r_state == HOLD:
          if (bus.out_ready) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_x3  <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_out <= '0;
    end else if (clr) begin
      r_x0  <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_x3  <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_out <= '0;
    end else if (w_accept) begin
      r_x3  <= r_x2;
      r_x2  <= r_x1;
      r_x1  <= r_x0;
      r_x0  <= bus.in_data;
      r_acc <= '0;
      r_k   <= '0;
    end else if (r_state == MAC) begin
      r_acc <= w_sum;
      if (w_last) begin
        r_out <= w_sum;
        r_k   <= '0;
      end else begin
        r_k   <= r_k + 2'd1;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_out;
  assign busy          = (r_state != IDLE);

endmodule

// File: doc/fir4_mac.md
FIR4_MAC -- requirements
Module: fir4_mac

Interface
REQ-001 Parameter C0, default 8'sd1, signed tap-0 coefficient (newest sample).
REQ-002 Parameter C1, default 8'sd3, signed tap-1 coefficient.
REQ-003 Parameter C2, default 8'sd3, signed tap-2 coefficient.
REQ-004 Parameter C3, default 8'sd1, signed tap-3 coefficient (oldest sample).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous flush of delay line and datapath.
REQ-008 in_data  input  8  unsigned sample.
REQ-009 in_valid  input  1  upstream offers in_data.
REQ-010 in_ready  output  1  block can accept a sample this cycle.
REQ-011 out_data  output  18  signed filter result, two's complement.
REQ-012 out_valid  output  1  out_data holds a result.
REQ-013 out_ready  input  1  downstream (digit/segment display stage) accepts result.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement y[n] = C0*x[n] + C1*x[n-1] + C2*x[n-2] + C3*x[n-3], x unsigned 8-bit zero-extended, C signed 8-bit.
REQ-016 The block SHALL hold a 4-entry delay line x0..x3 of 8-bit samples, x0 newest.
REQ-017 States SHALL be IDLE, MAC, HOLD; in_ready = 1 only in IDLE; out_valid = 1 only in HOLD.
REQ-018 IDLE: on in_valid & in_ready at an edge, x3<=x2, x2<=x1, x1<=x0, x0<=in_data, accumulator<=0, tap index k<=0, state->MAC.
REQ-019 MAC: one tap per cycle, acc <= acc + Ck*xk for k = 0,1,2,3; after the k=3 edge, out_data <= final sum, state->HOLD.
REQ-020 Latency SHALL be exactly 4 clock edges from the accepting edge to out_valid high.
REQ-021 Arithmetic: each product 17-bit signed, accumulator 18-bit signed; full range (-130560..+129540) fits without overflow; no saturation or rounding.
REQ-022 HOLD: out_data and out_valid SHALL stay stable until out_valid & out_ready at an edge; then out_valid drops and state->IDLE.
REQ-023 Simultaneous out_ready and in_valid in HOLD: result is consumed, no sample accepted that cycle (in_ready low); the sample is accepted at the next edge in IDLE if still valid.
REQ-024 in_data SHALL be ignored whenever in_ready is low; delay line changes only on an accepting edge.
REQ-025 clr high at an edge SHALL zero x0..x3, accumulator, k, out_data, drop out_valid, state->IDLE; clr has priority over all handshakes.
REQ-026 The 2-bit tap index SHALL never wrap within MAC; leaving MAC occurs only after k=3.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, x0..x3 = 0, acc = 0, k = 0, out_data = 0, out_valid = 0, in_ready = 1 (after reset release), busy = 0.
REQ-029 Reset asserted mid-MAC or in HOLD SHALL abandon the computation with no result emitted.
REQ-030 First sample after reset SHALL be filtered against zero history.

Verification
REQ-031 Impulse, default coefficients: samples 1,0,0,0,0 with out_ready=1 -> out_data 1,3,3,1,0; each out_valid exactly 4 edges after its accept.
REQ-032 Step: five samples of 255 -> out_data 255, 1020, 1785, 2040, 2040.
REQ-033 Extremes: C0..C3 = -128, four samples of 255 -> final out_data = -130560 (18'h20200); C0..C3 = 127 -> 129540.
REQ-034 Backpressure: out_ready=0 for 10 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no sample consumed; out_ready=1 -> result taken, next sample accepted one edge later.
REQ-035 Reset/clr mid-operation: rst_n low during MAC k=2 -> out_valid never rises, all outputs zero; clr during HOLD -> out_valid=0 next edge, next impulse 1 yields 1 (history cleared).
